// File: rtl/legv8_cache_ctrl.sv
// Direct-mapped tag-store sequencer: lookup, miss fetch handshake, fill, response, plus hit/miss counters.
// Hit responds 2 cycles after accept; miss holds mem_req until mem_ack; cpu_req_ready is high only in IDLE.
module legv8_cache_ctrl #(
    parameter int ADDR_W   = 64,
    parameter int OFFSET_W = 3,
    parameter int INDEX_W  = 4,
    parameter int TAG_W    = 57,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_hit,
    output logic [INDEX_W-1:0] cache_index,
    output logic [TAG_W-1:0]  cache_tag,
    output logic              cache_write,
    input  logic              cache_hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_FILL,
        S_RESP
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                hit_flag_q, hit_flag_d;
    logic [CNT_W-1:0]    hit_count_q, hit_count_d;
    logic [CNT_W-1:0]    miss_count_q, miss_count_d;

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        tag_d        = tag_q;
        mem_addr_d   = mem_addr_q;
        hit_flag_d   = hit_flag_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    index_d = cpu_req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
                    tag_d   = cpu_req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // An X/Z hit flag falls into the else branch, so it is handled as a miss.
                if (cache_hit == 1'b1) begin
                    hit_count_d = hit_count_q + CNT_ONE;
                    hit_flag_d  = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    miss_count_d = miss_count_q + CNT_ONE;
                    hit_flag_d   = 1'b0;
                    mem_addr_d   = {tag_q, index_q, {OFFSET_W{1'b0}}};
                    state_d      = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (mem_ack) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stat_clr) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            tag_q        <= '0;
            mem_addr_q   <= '0;
            hit_flag_q   <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            mem_addr_q   <= mem_addr_d;
            hit_flag_q   <= hit_flag_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign cpu_req_ready  = (state_q == S_IDLE);
    assign cpu_resp_valid = (state_q == S_RESP);
    assign cpu_resp_hit   = (state_q == S_RESP) && hit_flag_q;
    assign cache_write    = (state_q == S_FILL);
    assign mem_req        = (state_q == S_MISS_REQ);
    assign cache_index    = index_q;
    assign cache_tag      = tag_q;
    assign mem_addr       = mem_addr_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_legv8_cache_ctrl.sv
// Directed bench for legv8_cache_ctrl with a behavioural tag store; a 2-bit-counter instance exercises counter wrap.
module tb_legv8_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req_valid;
    logic [63:0] cpu_req_addr;
    logic        cache_hit;
    logic        mem_ack;
    logic        stat_clr;
    logic        force_x;

    logic        cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cache_write, mem_req;
    logic [3:0]  cache_index;
    logic [56:0] cache_tag;
    logic [63:0] mem_addr;
    logic [31:0] hit_count, miss_count;

    logic        w_ready, w_resp_valid, w_resp_hit, w_write, w_mem_req;
    logic [3:0]  w_index;
    logic [56:0] w_tag;
    logic [63:0] w_mem_addr;
    logic [1:0]  w_hit_count, w_miss_count;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_hit  = '0;
    logic [31:0] exp_miss = '0;

    logic [15:0] mv = '0;
    logic [56:0] mt [16];

    legv8_cache_ctrl u_dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
        .cache_index(cache_index), .cache_tag(cache_tag), .cache_write(cache_write), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .stat_clr(stat_clr), .hit_count(hit_count), .miss_count(miss_count)
    );

    legv8_cache_ctrl #(.CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr),
        .cpu_req_ready(w_ready), .cpu_resp_valid(w_resp_valid), .cpu_resp_hit(w_resp_hit),
        .cache_index(w_index), .cache_tag(w_tag), .cache_write(w_write), .cache_hit(cache_hit),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(mem_ack),
        .stat_clr(stat_clr), .hit_count(w_hit_count), .miss_count(w_miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tag store: valid+tag per set, written on fill, combinational hit.
    always @(posedge clk) begin
        if (cache_write) begin
            mv[cache_index] <= 1'b1;
            mt[cache_index] <= cache_tag;
        end
    end

    always_comb begin
        cache_hit = 1'b0;
        if (force_x) cache_hit = 1'bx;
        else         cache_hit = mv[cache_index] && (mt[cache_index] == cache_tag);
    end

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", t, got, exp);
    endtask

    task automatic check_counts(input string nm);
        chk({nm, "_hit_count"}, 64'(hit_count), 64'(exp_hit));
        chk({nm, "_miss_count"}, 64'(miss_count), 64'(exp_miss));
        chk({nm, "_wrap_hit_count"}, 64'(w_hit_count), 64'(exp_hit[1:0]));
        chk({nm, "_wrap_miss_count"}, 64'(w_miss_count), 64'(exp_miss[1:0]));
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic access(input logic [63:0] a, input int ack_wait, input bit exp_h, input string nm);
        int n, mreq, wr, wr_at, rdy, addr_bad;
        bit got;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        chk({nm, "_ready_idle"}, 64'(cpu_req_ready), 64'(1));
        @(negedge clk);
        cpu_req_valid = 1'b0;
        chk({nm, "_index"}, 64'(cache_index), 64'(a[6:3]));
        chk({nm, "_tag"}, 64'(cache_tag), 64'(a[63:7]));
        n = 1; mreq = 0; wr = 0; wr_at = 0; rdy = 0; addr_bad = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            mem_ack = 1'b0;
            if (cpu_req_ready) rdy++;
            if (mem_req) begin
                mreq++;
                if (mem_addr !== {a[63:3], 3'b000}) addr_bad++;
                if (mreq == ack_wait) mem_ack = 1'b1;
            end
            if (cache_write) begin
                wr++;
                wr_at = n;
            end
            if (cpu_resp_valid) got = 1'b1;
        end
        mem_ack = 1'b0;
        chk({nm, "_resp_seen"}, 64'(got), 64'(1));
        chk({nm, "_resp_hit"}, 64'(cpu_resp_hit), 64'(exp_h));
        chk({nm, "_latency"}, 64'(n), exp_h ? 64'(2) : 64'(3 + ack_wait));
        chk({nm, "_mem_req_cycles"}, 64'(mreq), exp_h ? 64'(0) : 64'(ack_wait));
        chk({nm, "_write_pulses"}, 64'(wr), exp_h ? 64'(0) : 64'(1));
        if (!exp_h) chk({nm, "_write_before_resp"}, 64'(wr_at), 64'(n - 1));
        chk({nm, "_mem_addr_errs"}, 64'(addr_bad), 64'(0));
        chk({nm, "_ready_busy"}, 64'(rdy), 64'(0));
        if (exp_h) exp_hit = exp_hit + 1;
        else       exp_miss = exp_miss + 1;
        check_counts(nm);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_t [3];
        int nacc, nresp, nbad, nrdylow, nwr, nrsp;

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0;
        mem_ack = 1'b0; stat_clr = 1'b0; force_x = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_ready", 64'(cpu_req_ready), 64'(1));
        chk("rst_resp_valid", 64'(cpu_resp_valid), 64'(0));
        chk("rst_resp_hit", 64'(cpu_resp_hit), 64'(0));
        chk("rst_write", 64'(cache_write), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_addr", mem_addr, 64'(0));
        chk("rst_index", 64'(cache_index), 64'(0));
        chk("rst_tag", 64'(cache_tag), 64'(0));
        chk("rst_hit_count", 64'(hit_count), 64'(0));
        chk("rst_miss_count", 64'(miss_count), 64'(0));
        chk("rst_w_ready", 64'(w_ready), 64'(1));
        chk("rst_w_resp", 64'({w_resp_valid, w_resp_hit, w_write, w_mem_req}), 64'(0));
        chk("rst_w_addr", w_mem_addr, 64'(0));
        chk("rst_w_index_tag", 64'({w_index, w_tag}), 64'(0));
        chk("rst_w_counts", 64'({w_hit_count, w_miss_count}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Cold miss at 0x1238: index 7, tag 0x24, block already aligned.
        access(64'h0000_0000_0000_1238, 4, 1'b0, "miss1");
        chk("miss1_index_val", 64'(cache_index), 64'(7));
        chk("miss1_tag_val", 64'(cache_tag), 64'(57'h24));
        access(64'h0000_0000_0000_1238, 0, 1'b1, "hit1");
        access(64'hDEAD_BEEF_0000_0A5F, 1, 1'b0, "miss_unal");
        chk("miss_unal_mem_addr", mem_addr, 64'hDEAD_BEEF_0000_0A58);

        // Three hits with the request held high the whole time.
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 64'h0000_0000_0000_1238;
        nacc = 0; nresp = 0; nbad = 0; nrdylow = 0;
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            if (cpu_req_valid && cpu_req_ready) begin
                if (nacc < 3) acc_t[nacc] = c;
                nacc++;
            end
            if (cpu_resp_valid) begin
                nresp++;
                if (!cpu_resp_hit) nbad++;
            end
            if (!cpu_req_ready) nrdylow++;
            @(negedge clk);
            if (nacc == 3) cpu_req_valid = 1'b0;
        end
        cpu_req_valid = 1'b0;
        exp_hit = exp_hit + 3;
        chk("b2b_accepts", 64'(nacc), 64'(3));
        chk("b2b_gap1", 64'(acc_t[1] - acc_t[0]), 64'(3));
        chk("b2b_gap2", 64'(acc_t[2] - acc_t[1]), 64'(3));
        chk("b2b_resps", 64'(nresp), 64'(3));
        chk("b2b_non_hits", 64'(nbad), 64'(0));
        chk("b2b_ready_low", 64'(nrdylow), 64'(6));
        check_counts("b2b");
        chk("wrap_to_zero", 64'(w_hit_count), 64'(0));
        @(negedge clk);

        // Unknown hit flag must be treated as a miss.
        force_x = 1'b1;
        access(64'h0000_0000_0000_1238, 2, 1'b0, "hit_x");
        force_x = 1'b0;

        // Clear coinciding with a lookup hit wins over the increment.
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 64'h0000_0000_0000_1238;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        exp_hit = '0;
        exp_miss = '0;
        chk("clr_resp_valid", 64'(cpu_resp_valid), 64'(1));
        chk("clr_resp_hit", 64'(cpu_resp_hit), 64'(1));
        check_counts("clr");
        @(negedge clk);
        access(64'h0000_0000_0000_1238, 0, 1'b1, "post_clr");

        // Reset while waiting on memory: drop the access, no late fill.
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 64'h0000_0000_0000_4000;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_req_a", 64'(mem_req), 64'(1));
        @(negedge clk);
        chk("rstmid_mem_req_b", 64'(mem_req), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hit = '0;
        exp_miss = '0;
        chk("rstmid_ready", 64'(cpu_req_ready), 64'(1));
        chk("rstmid_mem_req", 64'(mem_req), 64'(0));
        chk("rstmid_mem_addr", mem_addr, 64'(0));
        chk("rstmid_index_tag", 64'({cache_index, cache_tag}), 64'(0));
        check_counts("rstmid");
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        nwr = 0; nrsp = 0;
        for (int c = 0; c < 6; c++) begin
            if (cache_write) nwr++;
            if (cpu_resp_valid) nrsp++;
            @(negedge clk);
        end
        chk("rstmid_late_writes", 64'(nwr), 64'(0));
        chk("rstmid_late_resps", 64'(nrsp), 64'(0));
        chk("rstmid_still_idle", 64'(cpu_req_ready), 64'(1));
        access(64'h0000_0000_0000_1238, 0, 1'b1, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
